// File: rtl/data_memory_ws_if.sv
// data_memory_ws_if: request/ready bus between the execute stage and the wait-state data memory
interface data_memory_ws_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] be;
  logic              busy;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              err;
  modport master(output req, we, addr, wdata, be, input busy, ready, rdata, err);
  modport slave(input req, we, addr, wdata, be, output busy, ready, rdata, err);
endinterface

// File: rtl/data_memory_ws.sv
// data_memory_ws: wait-state data memory with byte enables and error reporting; DMEM_PERF_CNT_EN adds read/write counters
module data_memory_ws #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32,
  parameter int WAIT   = 2
) (
  input logic            clk,
  input logic            rst,
  data_memory_ws_if.slave bus
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0]    rd_count,
  output logic [15:0]    wr_count
`endif
);
  localparam int BW  = DATA_W / 8;
  localparam int OFS = $clog2(BW);
  localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [BW-1:0]     l_be;
  // Storage holds word ^ index, so a zero-initialised array reads back word i as i.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept, fin, a_we, bad;
  logic [ADDR_W-1:0] a_addr, a_idx;
  logic [DATA_W-1:0] a_wdata, cur, mask, nxt;
  logic [BW-1:0]     a_be;
  logic [AW-1:0]     widx;
  for (genvar k = 0; k < BW; k++) begin : g_mask
    assign mask[8*k +: 8] = {8{a_be[k]}};
  end
  // Decode the access completing this edge: latched request while waiting, live request on a zero-wait accept.
  always_comb begin
    accept  = bus.req && state != S_WAIT;
    fin     = (state == S_WAIT && cnt == 4'd0) || (accept && WAIT == 0);
    a_we    = state == S_WAIT ? l_we : bus.we;
    a_addr  = state == S_WAIT ? l_addr : bus.addr;
    a_wdata = state == S_WAIT ? l_wdata : bus.wdata;
    a_be    = state == S_WAIT ? l_be : bus.be;
    a_idx   = a_addr >> OFS;
    bad     = (a_addr & ADDR_W'(BW - 1)) != '0 || a_idx >= ADDR_W'(DEPTH);
    widx    = AW'(a_idx);
    cur     = mem[widx] ^ DATA_W'(widx);
    nxt     = ((cur & ~mask) | (a_wdata & mask)) ^ DATA_W'(widx);
  end
  // Handshake FSM with registered busy/ready/rdata/err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      l_we      <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      l_be      <= '0;
      bus.busy  <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      bus.err   <= 1'b0;
    end else begin
      bus.ready <= fin;
      bus.rdata <= fin && !a_we && !bad ? cur : '0;
      bus.err   <= fin && bad;
      bus.busy  <= 1'b0;
      if (accept) begin
        l_we    <= bus.we;
        l_addr  <= bus.addr;
        l_wdata <= bus.wdata;
        l_be    <= bus.be;
      end
      if (fin) state <= S_DONE;
      else if (accept) begin
        state    <= S_WAIT;
        cnt      <= 4'(WAIT - 1);
        bus.busy <= 1'b1;
      end else if (state == S_WAIT) begin
        cnt      <= cnt - 4'd1;
        bus.busy <= 1'b1;
      end else state <= S_IDLE;
    end
  end
  // Array commit on the DONE-entry edge; an edge under reset never commits.
  always_ff @(posedge clk) begin
    if (rst && fin && a_we && !bad) mem[widx] <= nxt;
  end
`ifdef DMEM_PERF_CNT_EN
  // Saturating counters of completed legal reads and writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      if (fin && !bad && !a_we && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (fin && !bad && a_we && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_memory_ws.sv
// tb_data_memory_ws: directed self-checking bench for data_memory_ws at WAIT=2, 0 and 3
module tb_data_memory_ws;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  data_memory_ws_if #(.DATA_W(32), .ADDR_W(32)) b2 ();
  data_memory_ws_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
  data_memory_ws_if #(.DATA_W(32), .ADDR_W(32)) b3 ();
`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rc2, wc2, rc0, wc0, rc3, wc3;
`endif
  data_memory_ws #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
`ifdef DMEM_PERF_CNT_EN
    , .rd_count(rc2), .wr_count(wc2)
`endif
  );
  data_memory_ws #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
`ifdef DMEM_PERF_CNT_EN
    , .rd_count(rc0), .wr_count(wc0)
`endif
  );
  data_memory_ws #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .WAIT(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
`ifdef DMEM_PERF_CNT_EN
    , .rd_count(rc3), .wr_count(wc3)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One access on the WAIT=2 instance; checks idle outputs, busy while waiting and latency.
  task automatic acc(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    chk({tag, "_idle_ready"}, 32'(b2.ready), 32'd0);
    chk({tag, "_idle_rdata"}, b2.rdata, 32'd0);
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d; b2.be = b;
    @(posedge clk);
    #1 b2.req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!b2.ready) chk({tag, "_busy"}, 32'(b2.busy), 32'd1);
    end while (!b2.ready && n < 20);
    chk({tag, "_latency"}, n, 32'd3);
    chk({tag, "_done_busy"}, 32'(b2.busy), 32'd0);
    chk({tag, "_rdata"}, b2.rdata, exp_rd);
    chk({tag, "_err"}, 32'(b2.err), 32'(exp_err));
  endtask
  initial begin
    int seen, first, second, pulses;
    {b2.req, b2.we, b2.addr, b2.wdata, b2.be} = '0;
    {b0.req, b0.we, b0.addr, b0.wdata, b0.be} = '0;
    {b3.req, b3.we, b3.addr, b3.wdata, b3.be} = '0;
    #1;
    chk("rst_busy", 32'(b2.busy), 32'd0);
    chk("rst_ready", 32'(b2.ready), 32'd0);
    chk("rst_rdata", b2.rdata, 32'd0);
    chk("rst_err", 32'(b2.err), 32'd0);
    @(negedge clk) rst = 1'b1;
    acc("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h4, 1'b0);
    acc("wr08", 1'b1, 32'h8, 32'hAABBCCDD, 4'b0011, 32'h0, 1'b0);
    acc("rd08", 1'b0, 32'h8, 32'h0, 4'h0, 32'h0000CCDD, 1'b0);
    acc("wr14_be0", 1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    acc("rd14", 1'b0, 32'h14, 32'h0, 4'h0, 32'h5, 1'b0);
    acc("rd06_mis", 1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 1'b1);
    acc("rd200_oor", 1'b0, 32'h200, 32'h0, 4'h0, 32'h0, 1'b1);
    acc("wr01_mis", 1'b1, 32'h1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    acc("wr200_oor", 1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    acc("rd00", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    acc("rd04", 1'b0, 32'h4, 32'h0, 4'h0, 32'h1, 1'b0);
    acc("rd1fc", 1'b0, 32'h1FC, 32'h0, 4'h0, 32'h7F, 1'b0);
    @(negedge clk);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'hC; b2.wdata = 32'h55; b2.be = 4'hF;
    @(posedge clk);
    #1 b2.req = 1'b0;
    @(negedge clk);
    chk("abort_wait_busy", 32'(b2.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(b2.busy), 32'd0);
    chk("abort_ready", 32'(b2.ready), 32'd0);
    chk("abort_rdata", b2.rdata, 32'd0);
    chk("abort_err", 32'(b2.err), 32'd0);
    @(negedge clk) rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b2.ready) seen++;
    end
    chk("abort_no_ready", seen, 32'd0);
    acc("rd0c", 1'b0, 32'hC, 32'h0, 4'h0, 32'h3, 1'b0);
    @(negedge clk);
    b0.req = 1'b1; b0.we = 1'b0; b0.addr = 32'h0;
    @(negedge clk);
    chk("w0_first_ready", 32'(b0.ready), 32'd1);
    chk("w0_first_rdata", b0.rdata, 32'h0);
    b0.addr = 32'h4;
    @(negedge clk);
    chk("w0_second_ready", 32'(b0.ready), 32'd1);
    chk("w0_second_rdata", b0.rdata, 32'h1);
    b0.req = 1'b0;
    @(negedge clk);
    chk("w0_end_ready", 32'(b0.ready), 32'd0);
    b3.req = 1'b1; b3.we = 1'b0; b3.addr = 32'h4;
    first = -1; second = -1; pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (b3.ready) begin
        pulses++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
        chk("w3_rdata", b3.rdata, 32'h1);
      end
    end
    b3.req = 1'b0;
    chk("w3_first", first, 32'd4);
    chk("w3_spacing", second - first, 32'd4);
    chk("w3_pulses", pulses, 32'd2);
`ifdef DMEM_PERF_CNT_EN
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    acc("pc_rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
    acc("pc_rd1", 1'b0, 32'h4, 32'h0, 4'h0, 32'h1, 1'b0);
    acc("pc_rd2", 1'b0, 32'h10, 32'h0, 4'h0, 32'h4, 1'b0);
    acc("pc_wr0", 1'b1, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
    acc("pc_wr1", 1'b1, 32'h24, 32'h0, 4'h0, 32'h0, 1'b0);
    acc("pc_mis", 1'b0, 32'h2, 32'h0, 4'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("pc_rd_count", 32'(rc2), 32'd3);
    chk("pc_wr_count", 32'(wc2), 32'd2);
    rst = 1'b0;
    #1;
    chk("pc_rd_rst", 32'(rc2), 32'd0);
    chk("pc_wr_rst", 32'(wc2), 32'd0);
    @(negedge clk) rst = 1'b1;
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_memory_ws.md
Name: data_memory_ws

Overview:
- Parametrised successor of the single-cycle data memory stage.
- Adds configurable data width, depth and wait-state latency, a request/ready handshake, per-byte write enables, and alignment/range error reporting.
- Sits between the execute stage (address/store data) and writeback (load data).
- Intended for the multi-cycle core, where the controller stalls until ready.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8, at least 8.
- DEPTH, 128, number of DATA_W words in the array.
- ADDR_W, 32, byte-address width.
- WAIT, 2, wait states per access; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request, sampled on the rising edge.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data.
- be  in  DATA_W/8  byte enables for writes; be[k] covers wdata[8k+7:8k].
- busy  out  1  access in progress; new req ignored.
- ready  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  load data; valid only while ready=1, else 0.
- err  out  1  misaligned or out-of-range access; valid with ready.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst); clock port is clk.
- Reset values: busy=0, ready=0, rdata=0, err=0, FSM=IDLE, wait counter=0.
- Array contents are not touched by reset. At time zero word i holds value i.
- Address decode:
  - OFS = log2(DATA_W/8).
  - Word index = addr[ADDR_W-1:OFS].
  - Misaligned: addr[OFS-1:0] != 0.
  - Out of range: word index >= DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - req=1 at an edge accepts the request and latches we, addr, wdata, be.
  - Go to WAIT with counter=WAIT-1, or go directly to DONE if WAIT=0.
- WAIT:
  - busy=1; counter decrements each edge.
  - When counter=0, go to DONE.
  - req is ignored while in WAIT.
- Entry to DONE (one edge):
  - ready=1 for exactly one cycle; busy=0 during DONE.
  - Legal read: rdata = array[index].
  - Legal write: array[index] byte k <= wdata byte k for each be[k]=1; rdata=0.
  - Illegal access: err=1, rdata=0, no array write.
- Latency: ready rises WAIT+1 edges after the accepting edge.
- DONE: req=1 at the next edge is accepted exactly as from IDLE, giving back-to-back throughput of one access per WAIT+1 cycles. Otherwise go to IDLE.
- be=0 on a write: completes normally with no change to the array.
- Read data reflects all writes completed on earlier edges. There is no same-edge hazard, because one access is in flight at most.
- Reset asserted mid-access:
  - Immediately returns to IDLE with all outputs 0.
  - A pending write is dropped, never committed.
  - No ready is issued for the aborted access.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - rd_count, 16-bit: completed legal reads.
  - wr_count, 16-bit: completed legal writes.
- Counters increment on the ready edge, saturate at 16'hFFFF, and reset to 0 asynchronously.
- Error accesses are not counted.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- WAIT=2, read addr 0x10 with req at edge 0 -> busy=1 at edges 1-2; ready=1 after edge 3 with rdata=32'h4, err=0.
- Write addr 0x8, wdata 0xAABBCCDD, be=4'b0011, then read 0x8 -> rdata=32'h0000CCDD.
- Read addr 0x6 (misaligned), then read addr 0x200 (index 128, out of range) -> each gives ready with err=1 and rdata=0; a subsequent read of 0x4 returns 1.
- Write addr 0xC, wdata 0x55, with rst pulsed low during WAIT -> no ready pulse; outputs 0; read 0xC returns 3.
- Back-to-back reads of 0x0 and 0x4 with req held high, WAIT=0 -> ready on consecutive cycles with rdata 0 then 1; WAIT=3 -> ready pulses 4 cycles apart.
- With DMEM_PERF_CNT_EN: 3 legal reads, 2 legal writes, 1 misaligned access -> rd_count=3, wr_count=2; after rst -> both 0.
